// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Brief    : Shares one single-port text VRAM between video scanout and a CPU
//            port using a fixed 8-clock character-cell slot schedule.
//            Optional macro VRAM_ARB_BLANK_CPU_EN grants phases 0/1 to the CPU
//            in cells without a video fetch.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clock_25,
    input  logic              reset,
    input  logic              cell_sync,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] vid_char,
    output logic [DATA_W-1:0] vid_attr,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0]        c_st_idle  = 2'd0;
    localparam logic [1:0]        c_st_issue = 2'd1;
    localparam logic [1:0]        c_st_ack   = 2'd2;
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    logic [2:0]        r_phase;
    logic [2:0]        w_phase_nxt;
    logic              r_fetch;
    logic              w_fetch_nxt;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              w_cpu_slot;
    logic              w_grant;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_cpu_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_vid_char;
    logic [DATA_W-1:0] r_vid_attr;
    logic              r_vid_valid;
    logic [DATA_W-1:0] r_cpu_rdata;

    // Every decision looks at the slot about to start, because mem_* are registered.
    // cell_sync/fetch_en arrive with the cycle that precedes phase 0.
    always_comb begin
        w_phase_nxt = cell_sync ? 3'd0 : r_phase + 3'd1;
        w_fetch_nxt = (w_phase_nxt == 3'd0) ? fetch_en : r_fetch;
    end

`ifdef VRAM_ARB_BLANK_CPU_EN
    assign w_cpu_slot = (w_phase_nxt >= 3'd2) || !w_fetch_nxt;
`else
    assign w_cpu_slot = (w_phase_nxt >= 3'd2);
`endif

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_phase      <= 3'd0;
            r_fetch      <= 1'b0;
            r_fetch_addr <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_fetch <= w_fetch_nxt;
            if (w_phase_nxt == 3'd0) begin
                r_fetch_addr <= fetch_addr;
            end
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ACK never grants, which spaces back-to-back CPU accesses by two clocks.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (cpu_req && w_cpu_slot) begin
                    w_grant     = 1'b1;
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: w_state_nxt = c_st_ack;
            c_st_ack:   w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_cpu_rd    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_fetch_nxt && (w_phase_nxt == 3'd0)) begin
                r_mem_addr <= fetch_addr;
            end else if (w_fetch_nxt && (w_phase_nxt == 3'd1)) begin
                r_mem_addr <= r_fetch_addr + c_addr_one;
            end else if (w_grant) begin
                r_mem_addr  <= cpu_addr;
                r_mem_we    <= cpu_we;
                r_mem_wdata <= cpu_wdata;
                r_cpu_rd    <= !cpu_we;
            end
        end
    end

    // Character data returns during phase 1, attribute data during phase 2.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_vid_char  <= '0;
            r_vid_attr  <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            r_vid_valid <= w_fetch_nxt && (w_phase_nxt == 3'd2);
            if (w_fetch_nxt && (w_phase_nxt == 3'd2)) begin
                r_vid_char <= mem_rdata;
            end
            if (r_vid_valid) begin
                r_vid_attr <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_cpu_rdata <= '0;
        end else if ((r_state == c_st_ack) && r_cpu_rd) begin
            r_cpu_rdata <= mem_rdata;
        end
    end

    // Returning bytes bypass straight out in their pulse cycle, then the copy holds.
    assign cpu_ack   = (r_state == c_st_ack);
    assign cpu_rdata = (cpu_ack && r_cpu_rd) ? mem_rdata : r_cpu_rdata;
    assign vid_char  = r_vid_char;
    assign vid_attr  = r_vid_valid ? mem_rdata : r_vid_attr;
    assign vid_valid = r_vid_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Self-checking bench for vram_arbiter with a VRAM model and
//            scoreboards for video fetches and CPU transactions.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic        clock_25 = 1'b0;
    logic        reset;
    logic        cell_sync;
    logic        fetch_en;
    logic [11:0] fetch_addr;
    logic [7:0]  vid_char;
    logic [7:0]  vid_attr;
    logic        vid_valid;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

`ifdef VRAM_ARB_BLANK_CPU_EN
    localparam int c_blank_lat = 2;
    localparam int c_blank_ph  = 0;
    localparam int c_rst_lat   = 2;
    localparam int c_rst_ph    = 1;
`else
    localparam int c_blank_lat = 4;
    localparam int c_blank_ph  = 2;
    localparam int c_rst_lat   = 3;
    localparam int c_rst_ph    = 2;
`endif

    typedef struct packed {
        logic        rd;
        logic [11:0] addr;
        logic [7:0]  data;
    } cpu_item_t;

    logic [7:0]  vram [4096];
    logic [15:0] vid_q [$];
    cpu_item_t   cpu_q [$];
    logic [2:0]  tb_phase = 3'd0;
    logic        tb_fetch = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] r_vid_exp;
    cpu_item_t   r_cpu_exp;

    vram_arbiter #(.ADDR_W(12), .DATA_W(8)) u_dut (
        .clock_25  (clock_25),
        .reset     (reset),
        .cell_sync (cell_sync),
        .fetch_en  (fetch_en),
        .fetch_addr(fetch_addr),
        .vid_char  (vid_char),
        .vid_attr  (vid_attr),
        .vid_valid (vid_valid),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #20 clock_25 = ~clock_25;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a) ^ 8'hC3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_25);
        #1;
    endtask

    // Synchronous-read VRAM: data for an address appears one clock later.
    always @(posedge clock_25) begin
        if (mem_we === 1'b1) vram[mem_addr] <= mem_wdata;
        mem_rdata <= vram[mem_addr];
    end

    // Reference cell timing: phase of the current slot and whether it fetches.
    always @(posedge clock_25) begin
        if (reset) begin
            tb_phase <= 3'd0;
            tb_fetch <= 1'b0;
        end else begin
            tb_phase <= cell_sync ? 3'd0 : tb_phase + 3'd1;
            if (cell_sync || tb_phase == 3'd7) tb_fetch <= fetch_en;
        end
    end

    always @(negedge clock_25) begin
        if (vid_valid === 1'b1) begin
            if (vid_q.size() == 0) begin
                chk("vid_spurious", 32'(vid_valid), 32'd0);
            end else begin
                r_vid_exp = vid_q.pop_front();
                chk("vid_char", 32'(vid_char), 32'(r_vid_exp[15:8]));
                chk("vid_attr", 32'(vid_attr), 32'(r_vid_exp[7:0]));
            end
        end
        if (cpu_ack === 1'b1) begin
            if (cpu_q.size() == 0) begin
                chk("cpu_spurious_ack", 32'(cpu_ack), 32'd0);
            end else begin
                r_cpu_exp = cpu_q.pop_front();
                if (r_cpu_exp.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(r_cpu_exp.data));
                else              chk("cpu_wr_mem", 32'(vram[r_cpu_exp.addr]), 32'(r_cpu_exp.data));
            end
        end
        if (tb_fetch && tb_phase < 3'd2) chk("we_in_vid_slot", 32'(mem_we), 32'd0);
    end

    task automatic start_cell(input logic fe, input logic [11:0] fa, input logic sync);
        cell_sync  = sync;
        fetch_en   = fe;
        fetch_addr = fa;
        if (fe) vid_q.push_back({vram[fa], vram[fa + 12'd1]});
    endtask

    // Raises a request now, waits for the ack and checks latency plus the issue slot.
    task automatic cpu_access(input string tag, input logic we, input logic [11:0] addr,
                              input logic [7:0] d, input int exp_lat, input int exp_ph);
        logic [11:0] pa;
        logic        pw;
        logic [7:0]  pd;
        logic [2:0]  pph;
        int          lat;
        lat = 0;
        pa = '0; pw = 1'b0; pd = '0; pph = '0;
        cpu_q.push_back('{rd: !we, addr: addr, data: d});
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = we ? d : 8'h00;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            pa = mem_addr; pw = mem_we; pd = mem_wdata; pph = tb_phase;
            tick();
            if (cpu_ack === 1'b1) lat = i;
        end
        cpu_req = 1'b0;
        if (lat == 0) begin
            chk({tag, "_ack_timeout"}, 32'(cpu_ack), 32'd1);
        end else begin
            chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_issue_phase"}, 32'(pph), 32'(exp_ph));
            chk({tag, "_issue_addr"}, 32'(pa), 32'(addr));
            chk({tag, "_issue_we"}, 32'(pw), 32'(we));
            if (we) chk({tag, "_issue_wdata"}, 32'(pd), 32'(d));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_vid_char"}, 32'(vid_char), 32'd0);
        chk({tag, "_vid_attr"}, 32'(vid_attr), 32'd0);
        chk({tag, "_vid_valid"}, 32'(vid_valid), 32'd0);
        chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) vram[i] = init_val(i);
        vram[12'h0A0] = 8'h41;
        vram[12'h0A1] = 8'h1F;
        reset = 1'b1; cell_sync = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
        tick(); tick(); tick();
        chk_reset_vals("reset");
        reset = 1'b0;

        // Video fetch with no CPU traffic.
        start_cell(1'b1, 12'h0A0, 1'b1);
        tick();
        cell_sync = 1'b0; fetch_en = 1'b0;
        chk("vid_p0_addr", 32'(mem_addr), 32'h0A0);
        chk("vid_p0_we", 32'(mem_we), 32'd0);
        tick();
        chk("vid_p1_addr", 32'(mem_addr), 32'h0A1);
        chk("vid_p1_we", 32'(mem_we), 32'd0);
        chk("vid_p1_valid", 32'(vid_valid), 32'd0);
        tick();
        chk("vid_p2_valid", 32'(vid_valid), 32'd1);
        chk("vid_p2_char", 32'(vid_char), 32'h41);
        chk("vid_p2_attr", 32'(vid_attr), 32'h1F);
        tick();
        chk("vid_p3_valid", 32'(vid_valid), 32'd0);
        chk("vid_p3_attr_hold", 32'(vid_attr), 32'h1F);

        // CPU write raised at phase 0 of a fetching cell.
        start_cell(1'b1, 12'h0A0, 1'b1);
        tick();
        cell_sync = 1'b0; fetch_en = 1'b0;
        cpu_access("wr", 1'b1, 12'h7CF, 8'h55, 3, 2);

        // Read raised in the ACK cycle: must wait one extra clock.
        cpu_access("rd", 1'b0, 12'h7CF, 8'h55, 3, 5);
        tick();
        chk("rd_hold", 32'(cpu_rdata), 32'h55);
        chk("ack_pulse", 32'(cpu_ack), 32'd0);

        // Request at phase 7 ahead of a fetching cell.
        start_cell(1'b1, 12'h0A0, 1'b0);
        cpu_access("coll", 1'b1, 12'h100, 8'hA5, 4, 2);
        fetch_en = 1'b0;

        // Request at phase 7 ahead of a blanking cell.
        tick(); tick(); tick(); tick();
        cpu_access("blank", 1'b0, 12'h100, 8'hA5, c_blank_lat, c_blank_ph);

        // cell_sync mid-cell restarts the schedule immediately.
        tick(); tick();
        start_cell(1'b1, 12'h7CE, 1'b1);
        tick();
        cell_sync = 1'b0; fetch_en = 1'b0;
        chk("trunc_p0_addr", 32'(mem_addr), 32'h7CE);
        tick();
        chk("trunc_p1_addr", 32'(mem_addr), 32'h7CF);
        tick(); tick(); tick();

        // Reset asserted in the ISSUE cycle of a write.
        start_cell(1'b0, 12'h000, 1'b1);
        tick();
        cell_sync = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h77;
        for (int i = 0; i < 6 && mem_we !== 1'b1; i++) tick();
        chk("rst_issue_seen", 32'(mem_we), 32'd1);
        reset = 1'b1;
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        chk_reset_vals("midrst");
        cpu_access("postrst", 1'b0, 12'h100, 8'hA5, c_rst_lat, c_rst_ph);
        tick(); tick(); tick(); tick();

        chk("vid_q_empty", 32'(vid_q.size()), 32'd0);
        chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
